// File: rtl/mbist_pkg.sv
// Shared widths, log-entry layout and saturating-count helper for the MBIST fail logger.
// Pure declarations: no latency, no flow control.
package mbist_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int TURN_W    = 4;
  localparam int FAILCNT_W = 8;

  localparam int LOG_TURN_W  = TURN_W;
  localparam int LOG_ADDR_W  = ADDR_W;
  localparam int LOG_EXP_W   = DATA_W;
  localparam int LOG_ACT_W   = DATA_W;
  localparam int LOG_ENTRY_W = LOG_TURN_W + LOG_ADDR_W + LOG_EXP_W + LOG_ACT_W;

  localparam logic [FAILCNT_W-1:0] FAILCNT_MAX = '1;

  typedef struct packed {
    logic [LOG_TURN_W-1:0] turn;
    logic [LOG_ADDR_W-1:0] addr;
    logic [LOG_EXP_W-1:0]  exp_dat;
    logic [LOG_ACT_W-1:0]  act_dat;
  } log_entry_t;

  function automatic logic [FAILCNT_W-1:0] sat_inc(input logic [FAILCNT_W-1:0] v);
    return (v == FAILCNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mbist_fail_fifo.sv
// First-word-fall-through fail log: head visible combinationally, push seen one cycle later.
// A push into a full FIFO is accepted only alongside a pop, otherwise reported on drop_o.
module mbist_fail_fifo
  import mbist_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  log_entry_t wdata_i,
  output log_entry_t head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       drop_o
);

  localparam int AW = $clog2(DEPTH);

  // Top pointer bit is the wrap flag; low bits index the storage.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  log_entry_t  mem_q [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & full_o & ~pop_ok;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/mbist_fail_log.sv
// MBIST miscompare detector with sticky flags, saturating count and FWFT fail log.
// Flags/count update one cycle after a compare; log full without a pop drops the entry and sets LOG_OVF.
module mbist_fail_log
  import mbist_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  MBISTEN,
  input  logic                  CMP_VALID,
  input  logic [ADDR_W-1:0]     ADDR_MBIST,
  input  logic [DATA_W-1:0]     DATA_DUT,
  input  logic [DATA_W-1:0]     EXP_DATA,
  input  logic [TURN_W-1:0]     GEN_TURN,
  input  logic                  LOG_RD,
  output logic                  FAIL_FLAG,
  output logic [FAILCNT_W-1:0]  FAIL_CNT,
  output logic                  LOG_EMPTY,
  output logic                  LOG_FULL,
  output logic                  LOG_OVF,
  output logic [LOG_TURN_W-1:0] LOG_TURN,
  output logic [LOG_ADDR_W-1:0] LOG_ADDR,
  output logic [LOG_EXP_W-1:0]  LOG_EXP,
  output logic [LOG_ACT_W-1:0]  LOG_ACT
);

  logic                 mben_q;
  logic                 fail_flag_q, fail_flag_d;
  logic [FAILCNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 run_start;
  logic                 fail_evt;
  logic                 log_drop;
  log_entry_t           wr_entry;
  log_entry_t           head;

  // Run-start clear outranks any compare or pop in the same cycle.
  assign run_start = MBISTEN & ~mben_q;
  assign fail_evt  = MBISTEN & CMP_VALID & (DATA_DUT != EXP_DATA) & ~run_start;

  assign wr_entry.turn    = GEN_TURN;
  assign wr_entry.addr    = ADDR_MBIST;
  assign wr_entry.exp_dat = EXP_DATA;
  assign wr_entry.act_dat = DATA_DUT;

  mbist_fail_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (nRESET),
    .clr_i   (run_start),
    .push_i  (fail_evt),
    .pop_i   (LOG_RD & ~run_start),
    .wdata_i (wr_entry),
    .head_o  (head),
    .empty_o (LOG_EMPTY),
    .full_o  (LOG_FULL),
    .drop_o  (log_drop)
  );

  always_comb begin
    fail_flag_d = fail_flag_q;
    fail_cnt_d  = fail_cnt_q;
    ovf_d       = ovf_q;
    if (run_start) begin
      fail_flag_d = 1'b0;
      fail_cnt_d  = '0;
      ovf_d       = 1'b0;
    end else if (fail_evt) begin
      fail_flag_d = 1'b1;
      fail_cnt_d  = sat_inc(fail_cnt_q);
      if (log_drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      mben_q      <= 1'b0;
      fail_flag_q <= 1'b0;
      fail_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mben_q      <= MBISTEN;
      fail_flag_q <= fail_flag_d;
      fail_cnt_q  <= fail_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign FAIL_FLAG = fail_flag_q;
  assign FAIL_CNT  = fail_cnt_q;
  assign LOG_OVF   = ovf_q;
  assign LOG_TURN  = head.turn;
  assign LOG_ADDR  = head.addr;
  assign LOG_EXP   = head.exp_dat;
  assign LOG_ACT   = head.act_dat;

endmodule
